// File: rtl/pe_gram_acc.sv
// Systolic Gram-matrix PE: forwards A/B operands east/south and accumulates a
// runtime-length dot product with optional saturation and overflow reporting.
module pe_gram_acc #(
   parameter int WIDTH     = 8,
   parameter int ACC_W     = 20,
   parameter int DIMENSION = 4,
   parameter int SIGNED    = 0,
   parameter int CNT_W     = $clog2(DIMENSION + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             sat_mode,
   input  logic [CNT_W-1:0] vec_len,
   input  logic [WIDTH-1:0] in_A,
   input  logic [WIDTH-1:0] in_B,
   output logic [WIDTH-1:0] out_A,
   output logic [WIDTH-1:0] out_B,
   output logic             en_o,
   output logic [ACC_W-1:0] P,
   output logic             P_valid,
   output logic             P_ovf
);

   localparam int PW = 2 * WIDTH;
   localparam int XW = ACC_W + 2;
   localparam bit SGN = (SIGNED != 0);
   localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] DIM_C = CNT_W'(DIMENSION);

   logic [ACC_W-1:0] acc, acc_next, clamp;
   logic [CNT_W-1:0] cnt, len_q, len_in, len_eff;
   logic             ovf_q, ovf_now, ovf_next, last;
   logic [PW-1:0]    a_x, b_x, prod;
   logic [XW-1:0]    prod_x, acc_x, base_x, sum_x;

   // Operands are widened to the product width first so one unsigned multiply
   // yields the correct low 2*WIDTH bits for both signed and unsigned modes.
   always_comb begin
      a_x = '0;
      b_x = '0;
      a_x[WIDTH-1:0] = in_A;
      b_x[WIDTH-1:0] = in_B;
      if (SGN) begin
         a_x[PW-1:WIDTH] = {WIDTH{in_A[WIDTH-1]}};
         b_x[PW-1:WIDTH] = {WIDTH{in_B[WIDTH-1]}};
      end
      prod = a_x * b_x;
   end

   always_comb begin
      prod_x = {{(XW-PW){SGN & prod[PW-1]}}, prod};
      acc_x  = {{2{SGN & acc[ACC_W-1]}}, acc};
      base_x = (cnt == '0) ? '0 : acc_x;
      sum_x  = base_x + prod_x;
      if (SGN) begin
         ovf_now = !((&sum_x[XW-1:ACC_W-1]) || !(|sum_x[XW-1:ACC_W-1]));
         clamp   = sum_x[XW-1] ? S_MIN : S_MAX;
      end else begin
         ovf_now = |sum_x[XW-1:ACC_W];
         clamp   = '1;
      end
      acc_next = (ovf_now && sat_mode) ? clamp : sum_x[ACC_W-1:0];
      ovf_next = ((cnt == '0) ? 1'b0 : ovf_q) | ovf_now;
   end

   always_comb begin
      len_in  = (vec_len == '0 || vec_len > DIM_C) ? DIM_C : vec_len;
      len_eff = (cnt == '0) ? len_in : len_q;
      last    = (cnt == len_eff - CNT_W'(1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_A <= '0;
         out_B <= '0;
         en_o  <= 1'b0;
      end else if (en) begin
         out_A <= in_A;
         out_B <= in_B;
         en_o  <= 1'b1;
      end else begin
         out_A <= '0;
         out_B <= '0;
         en_o  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         cnt     <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
         P       <= '0;
         P_valid <= 1'b0;
         P_ovf   <= 1'b0;
      end else if (clr) begin
         acc     <= '0;
         cnt     <= '0;
         ovf_q   <= 1'b0;
         P_valid <= 1'b0;
      end else if (en) begin
         if (cnt == '0) len_q <= len_in;
         acc   <= acc_next;
         ovf_q <= ovf_next;
         if (last) begin
            P       <= acc_next;
            P_ovf   <= ovf_next;
            P_valid <= 1'b1;
            cnt     <= '0;
         end else begin
            P_valid <= 1'b0;
            cnt     <= cnt + CNT_W'(1);
         end
      end else begin
         P_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pe_gram_acc.sv
// Directed bench for pe_gram_acc: default unsigned PE, a 16-bit unsigned PE and a
// 16-bit signed PE share one stimulus stream; each task checks its own outputs.
module tb_pe_gram_acc;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, clr = 1'b0, sat_mode = 1'b0;
   logic [2:0] vec_len = 3'd4;
   logic [7:0] in_A = '0, in_B = '0;

   logic [7:0]  oa0, ob0, oa1, ob1, oa2, ob2;
   logic        eo0, eo1, eo2, pv0, pv1, pv2, po0, po1, po2;
   logic [19:0] p0;
   logic [15:0] p1, p2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pe_gram_acc u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .sat_mode(sat_mode), .vec_len(vec_len),
      .in_A(in_A), .in_B(in_B), .out_A(oa0), .out_B(ob0), .en_o(eo0),
      .P(p0), .P_valid(pv0), .P_ovf(po0));

   pe_gram_acc #(.ACC_W(16)) u_dut16 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .sat_mode(sat_mode), .vec_len(vec_len),
      .in_A(in_A), .in_B(in_B), .out_A(oa1), .out_B(ob1), .en_o(eo1),
      .P(p1), .P_valid(pv1), .P_ovf(po1));

   pe_gram_acc #(.ACC_W(16), .SIGNED(1)) u_dut_s (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .sat_mode(sat_mode), .vec_len(vec_len),
      .in_A(in_A), .in_B(in_B), .out_A(oa2), .out_B(ob2), .en_o(eo2),
      .P(p2), .P_valid(pv2), .P_ovf(po2));

   // Present one cycle of stimulus, then sample 1 ns after the rising edge.
   task automatic cyc(input logic e, input logic [7:0] a, input logic [7:0] b, input logic c);
      en = e; in_A = a; in_B = b; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #12;
      vectors++; if ({oa0, ob0, eo0} !== 17'd0) begin miscompares++; $display("FAIL reset_fwd got %h exp 0", {oa0, ob0, eo0}); end
      vectors++; if ({p0, pv0, po0} !== 22'd0) begin miscompares++; $display("FAIL reset_P got %h exp 0", {p0, pv0, po0}); end
      vectors++; if ({p1, pv1, po1, p2, pv2, po2} !== 36'd0) begin miscompares++; $display("FAIL reset_P16 got %h exp 0", {p1, pv1, po1, p2, pv2, po2}); end
      rst = 1'b1;
   endtask

   task automatic test_back_to_back;
      logic [7:0] av [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
      logic [7:0] bv [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
      vec_len = 3'd4; sat_mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, av[i], bv[i], 1'b0);
         vectors++; if ({oa0, ob0, eo0} !== {av[i], bv[i], 1'b1}) begin miscompares++; $display("FAIL b2b_fwd[%0d] got %h exp %h", i, {oa0, ob0, eo0}, {av[i], bv[i], 1'b1}); end
         if (i < 3) begin
            vectors++; if (pv0 !== 1'b0) begin miscompares++; $display("FAIL b2b_early_valid[%0d] got %b exp 0", i, pv0); end
         end
      end
      vectors++; if ({pv0, po0, p0} !== {1'b1, 1'b0, 20'd70}) begin miscompares++; $display("FAIL b2b_P got v=%b o=%b P=%0d exp v=1 o=0 P=70", pv0, po0, p0); end
      cyc(1'b0, 8'd9, 8'd9, 1'b0);
      vectors++; if ({pv0, p0, oa0, eo0} !== {1'b0, 20'd70, 8'd0, 1'b0}) begin miscompares++; $display("FAIL b2b_idle got v=%b P=%0d oa=%0d eo=%b exp v=0 P=70 oa=0 eo=0", pv0, p0, oa0, eo0); end
   endtask

   task automatic test_bubbles;
      logic [7:0] av [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
      logic [7:0] bv [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
      int nvalid = 0;
      vec_len = 3'd4;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, av[i], bv[i], 1'b0);
         if (pv0) nvalid++;
         if (i < 3) begin
            // vec_len change mid-vector must be ignored
            vec_len = 3'd1;
            cyc(1'b0, 8'd77, 8'd77, 1'b0);
            if (pv0) nvalid++;
            cyc(1'b0, 8'd77, 8'd77, 1'b0);
            if (pv0) nvalid++;
            vec_len = 3'd4;
         end
      end
      vectors++; if ({pv0, po0, p0} !== {1'b1, 1'b0, 20'd70}) begin miscompares++; $display("FAIL bubble_P got v=%b o=%b P=%0d exp v=1 o=0 P=70", pv0, po0, p0); end
      cyc(1'b0, 8'd0, 8'd0, 1'b0);
      if (pv0) nvalid++;
      vectors++; if (nvalid !== 1) begin miscompares++; $display("FAIL bubble_valid_count got %0d exp 1", nvalid); end
   endtask

   task automatic test_overflow;
      vec_len = 3'd4;
      for (int s = 0; s < 2; s++) begin
         sat_mode = (s == 1);
         for (int i = 0; i < 4; i++) cyc(1'b1, 8'd255, 8'd255, 1'b0);
         vectors++; if ({pv1, po1, p1} !== {1'b1, 1'b1, (s == 1) ? 16'd65535 : 16'd63492}) begin miscompares++; $display("FAIL ovf16_sat%0d got v=%b o=%b P=%0d exp v=1 o=1 P=%0d", s, pv1, po1, p1, (s == 1) ? 65535 : 63492); end
         vectors++; if ({pv0, po0, p0} !== {1'b1, 1'b0, 20'd260100}) begin miscompares++; $display("FAIL ovf20_sat%0d got v=%b o=%b P=%0d exp v=1 o=0 P=260100", s, pv0, po0, p0); end
         vectors++; if ({po2, p2} !== {1'b0, 16'd4}) begin miscompares++; $display("FAIL ovf_signed_m1_sat%0d got o=%b P=%0d exp o=0 P=4", s, po2, p2); end
      end
      sat_mode = 1'b0;
   endtask

   task automatic test_signed;
      vec_len = 3'd2; sat_mode = 1'b0;
      cyc(1'b1, 8'h80, 8'h7F, 1'b0);
      cyc(1'b1, 8'hFF, 8'hFD, 1'b0);
      vectors++; if ({pv2, po2, p2} !== {1'b1, 1'b0, 16'hC083}) begin miscompares++; $display("FAIL signed_dot got v=%b o=%b P=%h exp v=1 o=0 P=c083", pv2, po2, p2); end
      vec_len = 3'd4; sat_mode = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h80, 8'h7F, 1'b0);
      vectors++; if ({pv2, po2, p2} !== {1'b1, 1'b1, 16'h8000}) begin miscompares++; $display("FAIL signed_sat got v=%b o=%b P=%h exp v=1 o=1 P=8000", pv2, po2, p2); end
      sat_mode = 1'b0;
   endtask

   task automatic test_lengths;
      logic [7:0]  av [3] = '{8'd3, 8'd5, 8'd7};
      logic [7:0]  bv [3] = '{8'd4, 8'd6, 8'd9};
      logic [19:0] pe [3] = '{20'd12, 20'd30, 20'd63};
      vec_len = 3'd1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, av[i], bv[i], 1'b0);
         vectors++; if ({pv0, po0, p0} !== {1'b1, 1'b0, pe[i]}) begin miscompares++; $display("FAIL len1[%0d] got v=%b o=%b P=%0d exp v=1 o=0 P=%0d", i, pv0, po0, p0, pe[i]); end
      end
      vec_len = 3'd0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'd1, 8'd1, 1'b0);
      vectors++; if ({pv0, p0} !== {1'b0, 20'd63}) begin miscompares++; $display("FAIL len0_early got v=%b P=%0d exp v=0 P=63", pv0, p0); end
      cyc(1'b1, 8'd1, 8'd1, 1'b0);
      vectors++; if ({pv0, p0} !== {1'b1, 20'd4}) begin miscompares++; $display("FAIL len0_full got v=%b P=%0d exp v=1 P=4", pv0, p0); end
   endtask

   task automatic test_clr_and_reset;
      int nvalid = 0;
      vec_len = 3'd4;
      cyc(1'b1, 8'd2, 8'd3, 1'b0);
      cyc(1'b1, 8'd2, 8'd3, 1'b0);
      cyc(1'b1, 8'd9, 8'd9, 1'b1);
      vectors++; if ({pv0, p0, oa0, eo0} !== {1'b0, 20'd4, 8'd9, 1'b1}) begin miscompares++; $display("FAIL clr_hold got v=%b P=%0d oa=%0d eo=%b exp v=0 P=4 oa=9 eo=1", pv0, p0, oa0, eo0); end
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b1, 8'(i), 8'(i + 4), 1'b0);
         if (pv0 && i < 4) nvalid++;
      end
      vectors++; if ({pv0, po0, p0, nvalid[3:0]} !== {1'b1, 1'b0, 20'd70, 4'd0}) begin miscompares++; $display("FAIL clr_next got v=%b o=%b P=%0d early=%0d exp v=1 o=0 P=70 early=0", pv0, po0, p0, nvalid); end
      cyc(1'b1, 8'd5, 8'd5, 1'b0);
      cyc(1'b1, 8'd5, 8'd5, 1'b0);
      rst = 1'b0;
      #1;
      vectors++; if ({oa0, ob0, eo0, p0, pv0, po0} !== 39'd0) begin miscompares++; $display("FAIL async_rst got %h exp 0", {oa0, ob0, eo0, p0, pv0, po0}); end
      #1;
      rst = 1'b1;
      vec_len = 3'd2;
      cyc(1'b1, 8'd2, 8'd2, 1'b0);
      vectors++; if (pv0 !== 1'b0) begin miscompares++; $display("FAIL rst_restart_early got v=%b exp 0", pv0); end
      cyc(1'b1, 8'd3, 8'd3, 1'b0);
      vectors++; if ({pv0, p0} !== {1'b1, 20'd13}) begin miscompares++; $display("FAIL rst_restart got v=%b P=%0d exp v=1 P=13", pv0, p0); end
      cyc(1'b0, 8'd0, 8'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_bubbles();
      test_overflow();
      test_signed();
      test_lengths();
      test_clr_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
